// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel/line counters, delayed active-low syncs and blank,
// plus a start-of-vblank pulse and a wrapping frame counter.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned SYNC_DELAY = 1
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       pix_en,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       vblank_start,
    output logic [7:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic [7:0] frame_q, frame_d;
    logic       hs_raw, vs_raw, blank_raw;

    assign DrawX        = h_cnt_q;
    assign DrawY        = v_cnt_q;
    assign frame_count  = frame_q;
    assign vblank_start = pix_en && (h_cnt_q == 10'd0) && (v_cnt_q == V_VIS);

    assign blank_raw = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign hs_raw    = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    assign vs_raw    = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        frame_d = frame_q;
        if (pix_en) begin
            if (h_cnt_q == H_MAX) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_MAX) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
            if (vblank_start) begin
                frame_d = frame_q + 8'd1;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q <= 10'd0;
            v_cnt_q <= 10'd0;
            frame_q <= 8'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            frame_q <= frame_d;
        end
    end

    // Each stage holds {hs, vs, blank}; stages reset to the inactive levels.
    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign hs    = hs_raw;
            assign vs    = vs_raw;
            assign blank = blank_raw;
        end else begin : g_delay
            logic [2:0] pipe_q [SYNC_DELAY];

            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < int'(SYNC_DELAY); i++) begin
                        pipe_q[i] <= 3'b110;
                    end
                end else if (pix_en) begin
                    pipe_q[0] <= {hs_raw, vs_raw, blank_raw};
                    for (int i = 1; i < int'(SYNC_DELAY); i++) begin
                        pipe_q[i] <= pipe_q[i-1];
                    end
                end
            end

            assign hs    = pipe_q[SYNC_DELAY-1][2];
            assign vs    = pipe_q[SYNC_DELAY-1][1];
            assign blank = pipe_q[SYNC_DELAY-1][0];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-enable bench: three timing generators (small raster at delay 0 and 3, full
// 640x480 at delay 1) compared every cycle against an arithmetic model of enabled-pixel count.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset_n;
    logic pix_en;

    logic [9:0] dx [3];
    logic [9:0] dy [3];
    logic       hs [3];
    logic       vs [3];
    logic       bl [3];
    logic       vb [3];
    logic [7:0] fc [3];

    int  n_cmp = 0;
    int  n_err = 0;
    longint n_pix;
    logic wrap_seen = 1'b0;
    logic [7:0] prev_fc_a = 8'd0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(3),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .SYNC_DELAY(0)
    ) u_a (
        .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en), .DrawX(dx[0]), .DrawY(dy[0]),
        .hs(hs[0]), .vs(vs[0]), .blank(bl[0]), .vblank_start(vb[0]), .frame_count(fc[0])
    );

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(3),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .SYNC_DELAY(3)
    ) u_b (
        .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en), .DrawX(dx[1]), .DrawY(dy[1]),
        .hs(hs[1]), .vs(vs[1]), .blank(bl[1]), .vblank_start(vb[1]), .frame_count(fc[1])
    );

    vga_timing_gen u_c (
        .vga_clk(clk), .reset_n(reset_n), .pix_en(pix_en), .DrawX(dx[2]), .DrawY(dy[2]),
        .hs(hs[2]), .vs(vs[2]), .blank(bl[2]), .vblank_start(vb[2]), .frame_count(fc[2])
    );

    // Enabled pixel edges since the last reset; everything the DUT shows derives from it.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) n_pix <= 0;
        else if (pix_en) n_pix <= n_pix + 1;
    end

    function automatic logic [31:0] model(int ht, int hv, int hfp, int hsw, int vt, int vv,
                                          int vfp, int vsw, int d, longint n, logic pe);
        longint h, v, m, mh, mv, fr;
        logic e_hs, e_vs, e_bl, e_vb;
        h = n % ht;
        v = (n / ht) % vt;
        e_vb = pe && (h == 0) && (v == vv);
        if (n >= d) begin
            m  = n - d;
            mh = m % ht;
            mv = (m / ht) % vt;
            e_bl = (mh < hv) && (mv < vv);
            e_hs = !((mh >= hv + hfp) && (mh < hv + hfp + hsw));
            e_vs = !((mv >= vv + vfp) && (mv < vv + vfp + vsw));
        end else begin
            e_hs = 1'b1;
            e_vs = 1'b1;
            e_bl = 1'b0;
        end
        fr = (n > vv * ht) ? ((n - vv * ht - 1) / (ht * vt) + 1) : 0;
        return {h[9:0], v[9:0], e_hs, e_vs, e_bl, e_vb, fr[7:0]};
    endfunction

    function automatic logic [31:0] observed(int i);
        return {dx[i], dy[i], hs[i], vs[i], bl[i], vb[i], fc[i]};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_a", observed(0), model(10, 4, 1, 2, 8, 4, 1, 1, 0, n_pix, pix_en));
        check("model_b", observed(1), model(10, 4, 1, 2, 8, 4, 1, 1, 3, n_pix, pix_en));
        check("model_c", observed(2),
              model(800, 640, 16, 96, 525, 480, 10, 2, 1, n_pix, pix_en));
        if (reset_n && prev_fc_a == 8'd255 && fc[0] == 8'd0) wrap_seen = 1'b1;
        prev_fc_a = fc[0];
    end

    task automatic check_reset_vals(string tag);
        for (int i = 1; i < 3; i++) begin
            check({tag, "_x"}, 32'(dx[i]), 32'd0);
            check({tag, "_y"}, 32'(dy[i]), 32'd0);
            check({tag, "_syncblank"}, 32'({hs[i], vs[i], bl[i]}), 32'b110);
            check({tag, "_vbs"}, 32'(vb[i]), 32'd0);
            check({tag, "_fc"}, 32'(fc[i]), 32'd0);
        end
        check({tag, "_a_xy"}, 32'({dx[0], dy[0], fc[0]}), 32'd0);
    endtask

    initial begin
        int k;
        reset_n = 1'b0;
        pix_en  = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("reset");

        // Deterministic first lines of the full-size raster, with a short stall.
        reset_n = 1'b1;
        k = 0;
        for (int c = 0; c < 1700; c++) begin
            @(posedge clk);
            #2;
            if (pix_en) k++;
            pix_en = !(c >= 100 && c < 105);
            case (k)
                1:   check("first_x", 32'({dx[2], bl[2], hs[2]}), {22'd0, 10'd1} << 2 | 32'b11);
                101: check("stall_x", 32'(dx[2]), 32'd101);
                640: check("blank_640", 32'(bl[2]), 32'd1);
                641: check("blank_641", 32'(bl[2]), 32'd0);
                656: check("hs_656", 32'(hs[2]), 32'd1);
                657: check("hs_657", 32'(hs[2]), 32'd0);
                752: check("hs_752", 32'(hs[2]), 32'd0);
                753: check("hs_753", 32'(hs[2]), 32'd1);
                800: check("line_wrap", 32'({dx[2], dy[2]}), 32'd1);
                default: ;
            endcase
        end

        // Random enables long enough for the small raster to wrap frame_count.
        for (int c = 0; c < 30000; c++) begin
            @(posedge clk);
            #2;
            pix_en = ($urandom_range(0, 3) != 0);
        end
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #2;
            pix_en = c[0];
        end

        // Mid-frame reset of the small raster at (3,2).
        pix_en = 1'b1;
        for (int c = 0; c < 200 && (n_pix % 80) != 23; c++) begin
            @(posedge clk);
            #2;
        end
        check("reach_3_2", 32'({dx[0], dy[0]}), {22'd0, 10'd3, 10'd2} >> 0 & 32'hFFFFF);
        reset_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #2;
            pix_en = ($urandom_range(0, 1) != 0);
        end

        check("fc_wrap_seen", 32'(wrap_seen), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480 @ 60 Hz raster scan that drives the pixel pipeline: free-running horizontal/vertical counters exported as DrawX/DrawY to the colour mapper, active-low hsync/vsync for the VGA connector, and the display-enable (`blank`) signal. Sync and blank are delayed by a programmable number of pixel stages so they stay aligned with the registered sprite/background ROM reads downstream. It also emits a once-per-frame pulse at the start of vertical blanking, plus a frame counter, for game-state and animation logic.

## Interface
- `H_VISIBLE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch (pixels)
- `H_SYNC`, 96: hsync width (pixels)
- `H_BP`, 48: horizontal back porch (pixels); H_TOTAL = sum = 800
- `V_VISIBLE`, 480: visible lines
- `V_FP`, 10: vertical front porch (lines)
- `V_SYNC`, 2: vsync width (lines)
- `V_BP`, 33: vertical back porch (lines); V_TOTAL = sum = 525
- `SYNC_DELAY`, 1: pixel stages of delay on hs/vs/blank, legal 0..7
- `vga_clk`  in  1  pixel-domain clock
- `reset_n`  in  1  asynchronous, active-low reset
- `pix_en`  in  1  pixel-advance enable (tie high at 25 MHz; strobe every 2nd cycle at 50 MHz)
- `DrawX`  out  10  current horizontal count, 0..H_TOTAL-1
- `DrawY`  out  10  current vertical count, 0..V_TOTAL-1
- `hs`  out  1  horizontal sync, active low, delayed SYNC_DELAY stages
- `vs`  out  1  vertical sync, active low, delayed SYNC_DELAY stages
- `blank`  out  1  display enable: 1 inside the visible area, 0 in blanking; delayed SYNC_DELAY stages
- `vblank_start`  out  1  one-cycle pulse at the first pixel of vertical blanking
- `frame_count`  out  8  frames completed since reset, wraps

## Operation
- Registered counters h_cnt and v_cnt; DrawX = h_cnt, DrawY = v_cnt, with no added delay.
- On a `vga_clk` edge with pix_en=1:
  - h_cnt increments.
  - At h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - At (H_TOTAL-1, V_TOTAL-1), both wrap to 0.
- pix_en=0: counters, delay line and frame_count hold.
- Raw decodes from the counters:
  - blank_raw = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE)
  - hs_raw = 0 iff H_VISIBLE+H_FP ≤ h_cnt < H_VISIBLE+H_FP+H_SYNC (656..751)
  - vs_raw = 0 iff V_VISIBLE+V_FP ≤ v_cnt < V_VISIBLE+V_FP+V_SYNC (490..491)
- hs/vs/blank pass through a SYNC_DELAY-deep shift register that advances only on pix_en. SYNC_DELAY=0 means the outputs are the raw decodes, combinational from the counter registers.
- vblank_start = pix_en && h_cnt==0 && v_cnt==V_VISIBLE. It is undelayed, aligned with DrawX/DrawY, and fires exactly once per frame.
- frame_count increments by 1 mod 256 on the edge where vblank_start=1.
- Width rules: counters are 10 bits. All compares are unsigned against the parameter sums, computed at elaboration. Counters never exceed TOTAL-1.

## Timing
- Reset (asynchronous assert, synchronous release):
  - h_cnt=0, v_cnt=0, frame_count=0.
  - Every delay stage is loaded with the inactive values hs=1, vs=1, blank=0.
  - vblank_start=0, since (0,0) is not a trigger point.
- First pix_en edge after release: DrawX=1, DrawY=0.
- Latency: hs/vs/blank correspond to the counter value from SYNC_DELAY enabled pixels earlier. With SYNC_DELAY=1, blank first rises one enabled pixel after reset release, and hs first falls at DrawX=657.
- Line period: 800 enabled cycles. Frame period: 420,000 enabled cycles.
- First vblank_start: after 480×800 = 384,000 enabled edges following reset.
- Reset asserted mid-frame: all state returns to its reset values immediately, with no partial-frame pulse. Timing restarts from (0,0).
- pix_en deasserted during the vblank_start decode cycle: no pulse. The pulse fires on the next enabled cycle at that count.

## Test plan
- **Reset values:** hold reset_n=0 with pix_en=1 → DrawX=0, DrawY=0, hs=1, vs=1, blank=0, vblank_start=0, frame_count=0. Release, 1 edge → DrawX=1.
- **Line wrap and hsync:** SYNC_DELAY=0, step a full line.
  - blank=1 for DrawX 0..639 and 0 for 640..799.
  - hs=0 exactly for DrawX 656..751.
  - After DrawX=799: DrawX=0, DrawY=1.
- **Frame wrap and vsync:**
  - vs=0 exactly for DrawY 490..491.
  - vblank_start is high in the single cycle at (0,480), and frame_count goes 0→1.
  - After (799,524): both counters read 0.
- **Delay alignment:** SYNC_DELAY=3 → hs/vs/blank equal the SYNC_DELAY=0 waveforms shifted by exactly 3 enabled pixels. DrawX/DrawY are unshifted.
- **Stall:** pix_en toggling 1,0,1,0 → DrawX advances only on enabled edges. A 50% enable gives an 840,000-cycle frame, and hs/vs pulse widths double in raw cycles.
- **Wrap and mid-frame reset:**
  - Run 256 frames → frame_count reads 255, then 0.
  - Assert reset_n at (300,200) → all outputs at reset values asynchronously, before the next clock edge.
